dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder on the processor's load/store port. Accepts one word
//   request at a time and returns read data or a write acknowledge after a fixed
//   latency. Errors on misaligned or out-of-range addresses. busy feeds the
//   control unit's stall logic so the PC holds while an access is outstanding.
// PARAMETERS
//   DEPTH_WORDS  64  number of 32-bit words; word index = req_addr[31:2]
//   LATENCY      2   cycles from accept edge to access edge; legal range >= 1
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept; transfer when valid & ready at edge
//   req_we     in   1   1 = store, 0 = load
//   req_be     in   4   store byte enables; be[i] writes wdata[8i+7:8i]
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   rsp_valid  out  1   one-cycle response strobe
//   rsp_rdata  out  32  load data; 0 for stores and errors
//   rsp_err    out  1   qualified by rsp_valid: misaligned or out of range
//   busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
//     Memory array is NOT cleared by reset; contents undefined until written.
//   FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid at edge: latch we/be/addr/wdata,
//     cnt <= LATENCY-1, go WAIT. No request: stay IDLE.
//   WAIT: req_ready=0. cnt!=0: cnt <= cnt-1. cnt==0: access edge, go RESP.
//   Access edge: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
//     err: no write; rsp_rdata<=0; rsp_err<=1.
//     store, no err: write enabled bytes only; be=4'b0000 is a legal no-op;
//       rsp_rdata<=0; rsp_err<=0.
//     load, no err: rsp_rdata <= full word (req_be ignored); rsp_err<=0.
//   RESP: rsp_valid=1 for exactly this cycle; req_ready=0; next edge -> IDLE.
//   Timing: accept at edge E0 -> rsp_valid high in cycle after edge E0+LATENCY.
//     Next accept no earlier than edge E0+LATENCY+2.
//   rsp_rdata/rsp_err hold last values while rsp_valid=0.
//   Requests presented while busy are not accepted; requester holds them stable
//     until req_ready. Inputs other than req_valid are don't-care when it is 0.
//   Reset mid-operation (WAIT or RESP): return to IDLE at that edge; a store not
//     yet at its access edge is discarded; no rsp_valid for aborted request.
//   Reset and req_valid in same cycle: reset wins, no accept.
//   Address arithmetic unsigned 32-bit; no wrap, indices >= DEPTH_WORDS error.
// TESTING (DEPTH_WORDS=64, LATENCY=2)
//   1 store 0xDEADBEEF @0x10 be=1111, then load @0x10 -> each rsp_valid in cycle
//     after edge E0+2; load rdata=0xDEADBEEF, err=0; busy high E0..RESP.
//   2 store 0x11223344 @0x20, store 0x0000AA00 be=0010 @0x20, load @0x20
//     -> 0x1122AA44; store be=0000 @0x20 then load -> still 0x1122AA44.
//   3 store @0x22 -> rsp_err=1, rdata=0; load @0x20 -> unchanged, err=0.
//   4 load @0x100 (index 64) -> rsp_err=1, rdata=0; load @0xFC -> err=0.
//   5 store 0x0 @0x30; store 0x55 @0x30, assert reset during WAIT -> no
//     rsp_valid, req_ready=1 cycle after reset drops; load @0x30 -> 0x0.
//   6 hold req_valid high over 2 loads -> req_ready=0 while busy, exactly one
//     accept per IDLE, responses in order, second accept at edge E0+4.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store port between the processor (master) and the data-memory
// responder (slave). Request channel, response strobe and the busy flag
// the control unit uses to stall the PC.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request at a time, performs the
// access LATENCY cycles after acceptance and returns a one-cycle response.
// Misaligned or out-of-range addresses complete with rsp_err and no write.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  // cnt_r only ever holds values 0..LATENCY-1
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]      DEPTH_LIMIT = 32'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] cnt_r;

  logic             we_r;
  logic [3:0]       be_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;

  logic             ready_r;
  logic             busy_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_err_r;

  logic [31:0]      mem [0:DEPTH_WORDS-1];

  logic             accept_s;
  logic             access_s;
  logic             err_s;
  logic [IDX_W-1:0] idx_s;

  assign accept_s = (state_r == IDLE) && bus.req_valid;
  assign access_s = (state_r == WAIT) && (cnt_r == CNT_ZERO);
  // Word index compared in full 30-bit width so high addresses never alias
  assign err_s    = (addr_r[1:0] != 2'b00) || ({2'b00, addr_r[31:2]} >= DEPTH_LIMIT);
  assign idx_s    = addr_r[IDX_W+1:2];

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (access_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latency counter and handshake flags, all registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ready_r     <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      rsp_valid_r <= (state_s == RESP);
      if (accept_s) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Capture the request on acceptance; held until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r    <= 1'b0;
      be_r    <= 4'b0000;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= bus.req_we;
      be_r    <= bus.req_be;
      addr_r  <= bus.req_addr;
      wdata_r <= bus.req_wdata;
    end
  end

  // Response payload produced at the access edge, held between responses
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (access_s) begin
      if (err_s) begin
        rsp_rdata_r <= 32'h0000_0000;
        rsp_err_r   <= 1'b1;
      end else if (we_r) begin
        rsp_rdata_r <= 32'h0000_0000;
        rsp_err_r   <= 1'b0;
      end else begin
        rsp_rdata_r <= mem[idx_s];
        rsp_err_r   <= 1'b0;
      end
    end
  end

  // Byte-enabled store at the access edge; array contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && access_s && we_r && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          mem[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule
